// File: rtl/mixer_lo_hop_sequencer_if.sv
// Control and LO bundle for the mixer LO hop sequencer.
//   master : drives the ui_in control pins, the external LO pair and the
//            divisor-table write port; observes the LO outputs and status.
//   slave  : the sequencer itself.
// Signals:
//   ext_lo_en, ext_lo_p, ext_lo_n : asynchronous external LO select and pair
//   hop_en, hop_len, dwell         : hopping control (slots used = hop_len+1)
//   dead_cfg                       : dead-time cycles at the start of each half
//   cfg_we, cfg_addr, cfg_wdata    : divisor table write port
//   lo_p, lo_n                     : registered non-overlapping LO to the mixer
//   mode, hop_slot, hop_pulse      : status
interface mixer_lo_hop_sequencer_if #(
    parameter int DIV_W   = 8,
    parameter int DEAD_W  = 3,
    parameter int DWELL_W = 16
);
    logic               ext_lo_en;
    logic               ext_lo_p;
    logic               ext_lo_n;
    logic               hop_en;
    logic [1:0]         hop_len;
    logic [DWELL_W-1:0] dwell;
    logic [DEAD_W-1:0]  dead_cfg;
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic [DIV_W-1:0]   cfg_wdata;
    logic               lo_p;
    logic               lo_n;
    logic [1:0]         mode;
    logic [1:0]         hop_slot;
    logic               hop_pulse;

    modport master (
        output ext_lo_en, ext_lo_p, ext_lo_n, hop_en, hop_len, dwell, dead_cfg,
               cfg_we, cfg_addr, cfg_wdata,
        input  lo_p, lo_n, mode, hop_slot, hop_pulse
    );

    modport slave (
        input  ext_lo_en, ext_lo_p, ext_lo_n, hop_en, hop_len, dwell, dead_cfg,
               cfg_we, cfg_addr, cfg_wdata,
        output lo_p, lo_n, mode, hop_slot, hop_pulse
    );
endinterface

// File: rtl/mixer_lo_hop_sequencer.sv
// Differential, non-overlapping LO generator for the Gilbert mixer core.
// A divide-by counter produces alternating P/N half-periods of div+1 clk
// cycles each, with dead_cfg blanked cycles at the start of every half.
// The divisor is taken from a 4-slot table and can hop between slots every
// `dwell` LO periods. The LO source can be handed over glitch-free to the
// external LO pins and back, with a 2-cycle all-off guard in each direction.
// Ports:
//   clk   : system clock
//   n_rst : asynchronous active-low reset
//   bus   : control/status bundle (slave side), see mixer_lo_hop_sequencer_if
module mixer_lo_hop_sequencer #(
    parameter int DIV_W   = 8,
    parameter int DEAD_W  = 3,
    parameter int DWELL_W = 16
) (
    input  logic                      clk,
    input  logic                      n_rst,
    mixer_lo_hop_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        MODE_INT    = 2'd0,
        MODE_TO_EXT = 2'd1,
        MODE_EXT    = 2'd2,
        MODE_TO_INT = 2'd3
    } mode_t;

    localparam int CMP_W = DIV_W + DEAD_W;

    // ------------------------------------------------------------------
    // Two-flop synchronisers: bit 0 = ext_lo_en, 1 = ext_lo_p, 2 = ext_lo_n
    // ------------------------------------------------------------------
    logic [2:0] async_in;
    logic [2:0] sync_s;

    assign async_in = {bus.ext_lo_n, bus.ext_lo_p, bus.ext_lo_en};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= async_in[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_s[gi] = sync_reg;
        end
    endgenerate

    logic ext_lo_en_s;
    logic ext_lo_p_s;
    logic ext_lo_n_s;

    assign ext_lo_en_s = sync_s[0];
    assign ext_lo_p_s  = sync_s[1];
    assign ext_lo_n_s  = sync_s[2];

    // ------------------------------------------------------------------
    // Divisor table. Registers (not RAM) because every entry resets to 3.
    // The read below sees the pre-write contents, so a load coinciding with
    // a write to the same slot picks up the old value.
    // ------------------------------------------------------------------
    logic [4*DIV_W-1:0] table_flat;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_table
            logic [DIV_W-1:0] entry_reg;
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    entry_reg <= DIV_W'(3);
                end else if (bus.cfg_we && (bus.cfg_addr == 2'(gi))) begin
                    entry_reg <= bus.cfg_wdata;
                end
            end
            assign table_flat[gi*DIV_W +: DIV_W] = entry_reg;
        end
    endgenerate

    function automatic logic [DIV_W-1:0] table_read(input logic [1:0] idx,
                                                    input logic [4*DIV_W-1:0] flat);
        logic [DIV_W-1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (idx == 2'(i)) r = flat[i*DIV_W +: DIV_W];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    mode_t              mode_reg, mode_next;
    logic               guard_cnt_reg, guard_cnt_next;   // 2-cycle guard in TO_EXT/TO_INT
    logic [DIV_W-1:0]   cnt_reg, cnt_next;
    logic               phase_reg, phase_next;           // 0 = P half, 1 = N half
    logic [DIV_W-1:0]   div_reg, div_next;
    logic [1:0]         slot_reg, slot_next;
    logic [DWELL_W-1:0] dwell_cnt_reg, dwell_cnt_next;
    logic               hop_pulse_reg, hop_pulse_next;
    logic               lo_p_reg, lo_p_next;
    logic               lo_n_reg, lo_n_next;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mode_reg      <= MODE_INT;
            guard_cnt_reg <= 1'b0;
            cnt_reg       <= '0;
            phase_reg     <= 1'b0;
            div_reg       <= DIV_W'(3);
            slot_reg      <= 2'd0;
            dwell_cnt_reg <= '0;
            hop_pulse_reg <= 1'b0;
            lo_p_reg      <= 1'b0;
            lo_n_reg      <= 1'b0;
        end else begin
            mode_reg      <= mode_next;
            guard_cnt_reg <= guard_cnt_next;
            cnt_reg       <= cnt_next;
            phase_reg     <= phase_next;
            div_reg       <= div_next;
            slot_reg      <= slot_next;
            dwell_cnt_reg <= dwell_cnt_next;
            hop_pulse_reg <= hop_pulse_next;
            lo_p_reg      <= lo_p_next;
            lo_n_reg      <= lo_n_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic               wrap;
    logic               boundary;
    logic               past_dead;
    logic [DWELL_W-1:0] dwell_eff;
    logic               dwell_done;
    logic [1:0]         hop_target;

    always_comb begin
        mode_next      = mode_reg;
        guard_cnt_next = guard_cnt_reg;
        cnt_next       = cnt_reg;
        phase_next     = phase_reg;
        div_next       = div_reg;
        slot_next      = slot_reg;
        dwell_cnt_next = dwell_cnt_reg;
        hop_pulse_next = 1'b0;
        lo_p_next      = 1'b0;
        lo_n_next      = 1'b0;

        wrap       = (cnt_reg == div_reg);
        // A full LO period ends on the last cycle of the N half.
        boundary   = (mode_reg == MODE_INT) && wrap && phase_reg;
        past_dead  = CMP_W'(cnt_reg) >= CMP_W'(bus.dead_cfg);
        dwell_eff  = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
        dwell_done = ({1'b0, dwell_cnt_reg} + (DWELL_W+1)'(1)) >= {1'b0, dwell_eff};
        hop_target = (slot_reg >= bus.hop_len) ? 2'd0 : slot_reg + 2'd1;

        // Mode FSM: mode changes out of INT only at a period boundary so the
        // internal LO never emits a runt half.
        unique case (mode_reg)
            MODE_INT: begin
                if (boundary && ext_lo_en_s) begin
                    mode_next      = MODE_TO_EXT;
                    guard_cnt_next = 1'b0;
                end
            end
            MODE_TO_EXT: begin
                if (guard_cnt_reg) mode_next = MODE_EXT;
                else               guard_cnt_next = 1'b1;
            end
            MODE_EXT: begin
                if (!ext_lo_en_s) begin
                    mode_next      = MODE_TO_INT;
                    guard_cnt_next = 1'b0;
                end
            end
            MODE_TO_INT: begin
                if (guard_cnt_reg) mode_next = MODE_INT;
                else               guard_cnt_next = 1'b1;
            end
            default: mode_next = MODE_INT;
        endcase

        if (mode_reg == MODE_INT) begin
            if (wrap) begin
                cnt_next   = '0;
                phase_next = ~phase_reg;
            end else begin
                cnt_next = cnt_reg + DIV_W'(1);
            end

            if (boundary) begin
                if (bus.hop_en) begin
                    if (dwell_done) begin
                        slot_next      = hop_target;
                        dwell_cnt_next = '0;
                        hop_pulse_next = (hop_target != slot_reg);
                    end else begin
                        dwell_cnt_next = dwell_cnt_reg + DWELL_W'(1);
                    end
                end else begin
                    slot_next      = 2'd0;
                    dwell_cnt_next = '0;
                    hop_pulse_next = (slot_reg != 2'd0);
                end
                div_next = table_read(slot_next, table_flat);
            end

            lo_p_next = ~phase_reg & past_dead;
            lo_n_next =  phase_reg & past_dead;
        end else begin
            // Generator parked at the start of a P half while handed over.
            cnt_next   = '0;
            phase_next = 1'b0;
            if ((mode_reg == MODE_TO_INT) && guard_cnt_reg) begin
                div_next = table_read(slot_reg, table_flat);
            end
            // Gate with mode_next so the pins go quiet in the same cycle that
            // mode reports TO_INT.
            if ((mode_reg == MODE_EXT) && (mode_next == MODE_EXT)) begin
                lo_p_next = ext_lo_p_s;
                lo_n_next = ext_lo_n_s & ~ext_lo_p_s;
            end
        end
    end

    assign bus.lo_p      = lo_p_reg;
    assign bus.lo_n      = lo_n_reg;
    assign bus.mode      = mode_reg;
    assign bus.hop_slot  = slot_reg;
    assign bus.hop_pulse = hop_pulse_reg;

endmodule
